// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types and helpers for the AXI-Stream multi-operand adder.
//   state_t : FSM encoding (IDLE, ACCUM, SEND), 2 bits.
//   cnt_w() : width of the operand counter for a given maximum group length.
// Optional build macro used by the adder slice: ADDER_SAT_EN (see axis_sat_add).
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SEND  = 2'd2
    } state_t;

    // Counter must be able to hold the value nops itself.
    function automatic int cnt_w(input int nops);
        return $clog2(nops + 1);
    endfunction

endpackage

// File: rtl/axis_sat_add.sv
// -----------------------------------------------------------------------------
// axis_sat_add
// Combinational unsigned adder used by the accumulator.
//   a, b  : TDATAW-bit unsigned operands
//   sum   : TDATAW-bit result
//   carry : carry out of bit TDATAW-1 (reported as overflow)
// Build macro ADDER_SAT_EN:
//   defined   -> sum clamps to all-ones whenever the add carries
//   undefined -> sum wraps modulo 2^TDATAW
// Because a saturated accumulator is all-ones, any further non-zero operand
// carries again, so saturation sticks for the rest of the group without any
// extra state.
// -----------------------------------------------------------------------------
module axis_sat_add #(
    parameter int TDATAW = 32
) (
    input  logic [TDATAW-1:0] a,
    input  logic [TDATAW-1:0] b,
    output logic [TDATAW-1:0] sum,
    output logic              carry
);

    logic [TDATAW:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign carry  = w_full[TDATAW];

`ifdef ADDER_SAT_EN
    assign sum = carry ? {TDATAW{1'b1}} : w_full[TDATAW-1:0];
`else
    assign sum = w_full[TDATAW-1:0];
`endif

endmodule

// File: rtl/axis_multi_adder.sv
// -----------------------------------------------------------------------------
// axis_multi_adder
// Sums groups of up to NOPS unsigned operands received on an AXI-Stream slave
// and emits one result beat per group on an AXI-Stream master. A group ends
// after NOPS operands or on AXIS_S_TLAST, whichever comes first.
// Build macro ADDER_SAT_EN selects saturating instead of wrapping arithmetic
// (handled entirely inside axis_sat_add; the FSM is the same in both builds).
//
// Ports:
//   CLK, RST_N         : clock (rising edge), asynchronous active-low reset
//   AXIS_S_TVALID/READY: operand handshake
//   AXIS_S_TDATA       : unsigned operand
//   AXIS_S_TLAST       : last operand of a group
//   AXIS_S_TID         : group ID, sampled on the group's first operand
//   AXIS_S_TDEST       : ignored
//   AXIS_M_TVALID/READY: result handshake
//   AXIS_M_TDATA       : group sum
//   AXIS_M_TLAST       : 1 with every result
//   AXIS_M_TID         : TID of the group's first operand
//   AXIS_M_TDEST       : RESULT_DEST
//   AXIS_M_TUSER       : an add in this group carried out
// -----------------------------------------------------------------------------
module axis_multi_adder
    import adder_pkg::*;
#(
    parameter int TDATAW      = 32,
    parameter int TDESTW      = 4,
    parameter int TIDW        = 2,
    parameter int NOPS        = 2,
    parameter int RESULT_DEST = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TIDW-1:0]   AXIS_S_TID,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TIDW-1:0]   AXIS_M_TID,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    output logic              AXIS_M_TUSER
);

    localparam int CNTW = cnt_w(NOPS);

    state_t            r_state;
    logic [TDATAW-1:0] r_acc;
    logic [CNTW-1:0]   r_cnt;
    logic              r_ovf;
    logic [TIDW-1:0]   r_tid;

    logic              w_send;
    logic              w_s_beat;
    logic              w_m_beat;
    logic [TDATAW-1:0] w_sum;
    logic              w_carry;
    logic [CNTW-1:0]   w_cnt_nxt;
    logic              w_grp_end;
    logic              w_unused;

    assign w_unused = ^AXIS_S_TDEST;

    assign w_send = (r_state == SEND);

    // While a result is held, a new operand may only enter in the same cycle
    // the result leaves; this is what chains groups without a bubble.
    assign AXIS_S_TREADY = RST_N && (w_send ? AXIS_M_TREADY : 1'b1);

    assign w_s_beat  = AXIS_S_TVALID && AXIS_S_TREADY;
    assign w_m_beat  = w_send && AXIS_M_TREADY;
    assign w_cnt_nxt = r_cnt + CNTW'(1);
    assign w_grp_end = AXIS_S_TLAST || (w_cnt_nxt == CNTW'(NOPS));

    axis_sat_add #(
        .TDATAW (TDATAW)
    ) u_add (
        .a     (r_acc),
        .b     (AXIS_S_TDATA),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_tid   <= '0;
        end else begin
            case (r_state)
                // In SEND an accepted operand implies the result left this
                // cycle, so it is loaded exactly like a fresh group.
                IDLE, SEND: begin
                    if (w_s_beat) begin
                        r_acc   <= AXIS_S_TDATA;
                        r_cnt   <= CNTW'(1);
                        r_ovf   <= 1'b0;
                        r_tid   <= AXIS_S_TID;
                        r_state <= AXIS_S_TLAST ? SEND : ACCUM;
                    end else if (w_m_beat) begin
                        r_state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (w_s_beat) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_carry;
                        r_cnt <= w_cnt_nxt;
                        if (w_grp_end) begin
                            r_state <= SEND;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registers only; zero whenever no result is held.
    assign AXIS_M_TVALID = w_send;
    assign AXIS_M_TDATA  = w_send ? r_acc : '0;
    assign AXIS_M_TLAST  = w_send;
    assign AXIS_M_TID    = w_send ? r_tid : '0;
    assign AXIS_M_TDEST  = w_send ? TDESTW'(RESULT_DEST) : '0;
    assign AXIS_M_TUSER  = w_send ? r_ovf : 1'b0;

endmodule

// File: tb/tb_axis_multi_adder.sv
// -----------------------------------------------------------------------------
// tb_axis_multi_adder
// Two instances share one input stream: u_a (defaults: 32-bit, NOPS=2) and
// u_b (8-bit, NOPS=4, sees the low byte of each operand). A reference model
// per instance collects accepted operands into groups, reduces each finished
// group with plain arithmetic, and checks the expected result queue against
// the master port every cycle. Honours ADDER_SAT_EN like the design.
// -----------------------------------------------------------------------------
module tb_axis_multi_adder;

    logic        clk;
    logic        rst_n;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic [1:0]  s_tid;
    logic [3:0]  s_tdest;
    logic        m_tready;

    logic        a_s_tready, a_m_tvalid, a_m_tlast, a_m_tuser;
    logic [31:0] a_m_tdata;
    logic [1:0]  a_m_tid;
    logic [3:0]  a_m_tdest;

    logic        b_s_tready, b_m_tvalid, b_m_tlast, b_m_tuser;
    logic [7:0]  b_m_tdata;
    logic [1:0]  b_m_tid;
    logic [3:0]  b_m_tdest;

    axis_multi_adder u_a (
        .CLK(clk), .RST_N(rst_n),
        .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(a_s_tready),
        .AXIS_S_TDATA(s_tdata), .AXIS_S_TLAST(s_tlast),
        .AXIS_S_TID(s_tid), .AXIS_S_TDEST(s_tdest),
        .AXIS_M_TVALID(a_m_tvalid), .AXIS_M_TREADY(m_tready),
        .AXIS_M_TDATA(a_m_tdata), .AXIS_M_TLAST(a_m_tlast),
        .AXIS_M_TID(a_m_tid), .AXIS_M_TDEST(a_m_tdest),
        .AXIS_M_TUSER(a_m_tuser)
    );

    axis_multi_adder #(.TDATAW(8), .NOPS(4)) u_b (
        .CLK(clk), .RST_N(rst_n),
        .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(b_s_tready),
        .AXIS_S_TDATA(s_tdata[7:0]), .AXIS_S_TLAST(s_tlast),
        .AXIS_S_TID(s_tid), .AXIS_S_TDEST(s_tdest),
        .AXIS_M_TVALID(b_m_tvalid), .AXIS_M_TREADY(m_tready),
        .AXIS_M_TDATA(b_m_tdata), .AXIS_M_TLAST(b_m_tlast),
        .AXIS_M_TID(b_m_tid), .AXIS_M_TDEST(b_m_tdest),
        .AXIS_M_TUSER(b_m_tuser)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance views of the DUT outputs.
    logic        ob_rdy  [2];
    logic        ob_vld  [2];
    logic [31:0] ob_data [2];
    logic        ob_last [2];
    logic [1:0]  ob_tid  [2];
    logic [3:0]  ob_dest [2];
    logic        ob_user [2];

    assign ob_rdy[0]  = a_s_tready;  assign ob_rdy[1]  = b_s_tready;
    assign ob_vld[0]  = a_m_tvalid;  assign ob_vld[1]  = b_m_tvalid;
    assign ob_data[0] = a_m_tdata;   assign ob_data[1] = {24'd0, b_m_tdata};
    assign ob_last[0] = a_m_tlast;   assign ob_last[1] = b_m_tlast;
    assign ob_tid[0]  = a_m_tid;     assign ob_tid[1]  = b_m_tid;
    assign ob_dest[0] = a_m_tdest;   assign ob_dest[1] = b_m_tdest;
    assign ob_user[0] = a_m_tuser;   assign ob_user[1] = b_m_tuser;

    typedef struct {
        longint unsigned data;
        bit              ovf;
        int              tid;
    } res_t;

    int              checks = 0;
    int              errors = 0;
    int              nops_of [2] = '{2, 4};
    int              width_of[2] = '{32, 8};
    longint unsigned grp     [2][$];
    int              grp_tid [2];
    res_t            expq    [2][$];
    int              mbeats  [2] = '{0, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Group result from the arithmetic rules: unsigned sum, overflow on any
    // carry past the operand width, then wrap or clamp.
    function automatic res_t reduce(input longint unsigned ops[$], input int w, input int tid);
        res_t            r;
        longint unsigned lim;
        longint unsigned t;
        lim   = 64'd1 << w;
        r.data = ops[0];
        r.ovf  = 1'b0;
        r.tid  = tid;
        for (int i = 1; i < ops.size(); i++) begin
            t = r.data + ops[i];
            if (t >= lim) begin
                r.ovf = 1'b1;
`ifdef ADDER_SAT_EN
                r.data = lim - 1;
`else
                r.data = t - lim;
`endif
            end else begin
                r.data = t;
            end
        end
        return r;
    endfunction

    // One clock: entered at a falling edge with inputs already driven.
    task automatic step();
        bit              exp_vld;
        bit              exp_rdy;
        res_t            r;
        longint unsigned mask;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk($sformatf("rst_s_tready%0d", k), ob_rdy[k], 1'b0);
                chk($sformatf("rst_m_tvalid%0d", k), ob_vld[k], 1'b0);
                chk($sformatf("rst_m_tdata%0d", k), ob_data[k], 0);
                grp[k].delete();
                expq[k].delete();
            end else begin
                exp_vld = (expq[k].size() != 0);
                exp_rdy = !(exp_vld && !m_tready);
                chk($sformatf("m_tvalid%0d", k), ob_vld[k], exp_vld);
                chk($sformatf("s_tready%0d", k), ob_rdy[k], exp_rdy);
                if (exp_vld) begin
                    r = expq[k][0];
                    chk($sformatf("m_tdata%0d", k), ob_data[k], r.data);
                    chk($sformatf("m_tid%0d", k), ob_tid[k], r.tid);
                    chk($sformatf("m_tuser%0d", k), ob_user[k], r.ovf);
                    chk($sformatf("m_tlast%0d", k), ob_last[k], 1'b1);
                    chk($sformatf("m_tdest%0d", k), ob_dest[k], 4'd1);
                    if (m_tready) begin
                        void'(expq[k].pop_front());
                        mbeats[k]++;
                    end
                end
                if (s_tvalid && ob_rdy[k]) begin
                    mask = (64'd1 << width_of[k]) - 1;
                    if (grp[k].size() == 0) grp_tid[k] = s_tid;
                    grp[k].push_back(s_tdata & mask);
                    if (s_tlast || grp[k].size() == nops_of[k]) begin
                        expq[k].push_back(reduce(grp[k], width_of[k], grp_tid[k]));
                        grp[k].delete();
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input logic [1:0] id);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        s_tid    = id;
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [31:0] a_hold;
    logic [1:0]  a_tid_hold;
    int          a_before;
    int          b_before;

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tid    = '0;
        s_tdest  = 4'hA;
        m_tready = 1'b1;
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Two-operand group on u_a, valid the cycle after the 2nd operand.
        beat(32'd5, 1'b0, 2'd1);
        beat(32'd7, 1'b0, 2'd1);
        chk("tp1_valid", a_m_tvalid, 1'b1);
        chk("tp1_data",  a_m_tdata, 32'd12);
        chk("tp1_tid",   a_m_tid, 2'd1);
        chk("tp1_user",  a_m_tuser, 1'b0);
        // Close u_b's group; u_a sees a one-operand group.
        beat(32'd1, 1'b1, 2'd3);
        chk("tp1_b_data", b_m_tdata, 8'd13);
        chk("tp1_a_single", a_m_tdata, 32'd1);
        chk("tp1_a_single_tid", a_m_tid, 2'd3);
        idle(1);

        // TLAST on the 3rd operand, then a full-length group.
        beat(32'd1, 1'b0, 2'd0);
        beat(32'd2, 1'b0, 2'd0);
        beat(32'd3, 1'b1, 2'd0);
        chk("tp2_b_tlast", b_m_tdata, 8'd6);
        beat(32'd10, 1'b0, 2'd2);
        beat(32'd20, 1'b0, 2'd2);
        beat(32'd30, 1'b0, 2'd2);
        beat(32'd40, 1'b0, 2'd2);
        chk("tp2_b_full", b_m_tdata, 8'd100);
        chk("tp2_a_pair", a_m_tdata, 32'd70);
        idle(1);

        // Overflow in the 8-bit instance.
        beat(32'hF0, 1'b0, 2'd1);
        beat(32'h20, 1'b1, 2'd1);
        chk("tp3_a_data", a_m_tdata, 32'h110);
        chk("tp3_a_user", a_m_tuser, 1'b0);
`ifdef ADDER_SAT_EN
        chk("tp3_b_data", b_m_tdata, 8'hFF);
`else
        chk("tp3_b_data", b_m_tdata, 8'h10);
`endif
        chk("tp3_b_user", b_m_tuser, 1'b1);
        idle(1);

        // Back-pressure: hold the result for 5 cycles with an operand waiting.
        m_tready = 1'b0;
        beat(32'd11, 1'b0, 2'd3);
        beat(32'd22, 1'b1, 2'd3);
        a_hold     = a_m_tdata;
        a_tid_hold = a_m_tid;
        chk("tp4_a_held", a_hold, 32'd33);
        s_tvalid = 1'b1;
        s_tdata  = 32'd99;
        s_tlast  = 1'b0;
        s_tid    = 2'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("tp4_stall_rdy", a_s_tready, 1'b0);
            chk("tp4_stable_data", a_m_tdata, a_hold);
            chk("tp4_stable_tid", a_m_tid, a_tid_hold);
        end
        m_tready = 1'b1;
        beat(32'd9, 1'b0, 2'd2);
        chk("tp4_chain_a_accum", a_m_tvalid, 1'b0);
        beat(32'd1, 1'b1, 2'd0);
        chk("tp4_chain_tid", a_m_tid, 2'd2);
        chk("tp4_chain_data", a_m_tdata, 32'd10);
        idle(1);

        // Continuous stream: 8 operands, no TLAST.
        a_before = mbeats[0];
        b_before = mbeats[1];
        for (int i = 0; i < 8; i++) begin
            beat($urandom, 1'b0, 2'($urandom_range(0, 3)));
            chk("tp5_no_bubble", a_s_tready, 1'b1);
        end
        idle(1);
        chk("tp5_a_results", mbeats[0] - a_before, 4);
        chk("tp5_b_results", mbeats[1] - b_before, 2);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            s_tlast  = ($urandom_range(0, 3) == 0);
            s_tid    = 2'($urandom_range(0, 3));
            s_tdest  = 4'($urandom_range(0, 15));
            m_tready = ($urandom_range(0, 3) != 0);
            step();
        end
        m_tready = 1'b1;
        beat(32'd0, 1'b1, 2'd0);
        idle(2);

        // Reset after one of two operands discards the partial group.
        beat(32'd3, 1'b0, 2'd1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        beat(32'd3, 1'b0, 2'd2);
        beat(32'd4, 1'b0, 2'd2);
        chk("tp6_a_data", a_m_tdata, 32'd7);
        chk("tp6_a_tid", a_m_tid, 2'd2);
        beat(32'd0, 1'b1, 2'd0);
        chk("tp6_b_data", b_m_tdata, 8'd7);
        idle(1);

        // Reset while a result is held: it must never appear.
        m_tready = 1'b0;
        beat(32'd5, 1'b1, 2'd1);
        rst_n = 1'b0;
        idle(1);
        rst_n    = 1'b1;
        m_tready = 1'b1;
        idle(2);
        chk("tp6_send_dropped", a_m_tvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_multi_adder.md
Name: axis_multi_adder

Overview:
- Parametrised successor to the two-operand stream adder.
- Sums a group of up to NOPS operands arriving on an AXI-Stream slave and emits one result beat per group on an AXI-Stream master.
- A group ends after NOPS beats or on TLAST, whichever comes first.
- Overflow is flagged in TUSER; output is fully registered, and back-to-back groups run without a bubble.

Parameters:
- TDATAW, 32, operand and result width.
- TDESTW, 4, TDEST width.
- TIDW, 2, TID width.
- NOPS, 2, maximum operands per group; legal range 2 to 255.
- RESULT_DEST, 1, constant driven on AXIS_M_TDEST with every result.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- AXIS_S_TVALID  in  1  operand valid.
- AXIS_S_TREADY  out  1  operand ready.
- AXIS_S_TDATA  in  TDATAW  unsigned operand.
- AXIS_S_TLAST  in  1  marks the last operand of a group.
- AXIS_S_TID  in  TIDW  group ID; sampled on the first beat only.
- AXIS_S_TDEST  in  TDESTW  ignored.
- AXIS_M_TVALID  out  1  result valid.
- AXIS_M_TREADY  in  1  result ready.
- AXIS_M_TDATA  out  TDATAW  group sum.
- AXIS_M_TLAST  out  1  always 1 while TVALID is high.
- AXIS_M_TID  out  TIDW  TID of the group's first beat.
- AXIS_M_TDEST  out  TDESTW  RESULT_DEST.
- AXIS_M_TUSER  out  1  overflow occurred in this group.

Behaviour:
- Reset, asynchronous, RST_N low:
  - state=IDLE; acc, cnt, ovf = 0.
  - All AXIS_M_* outputs = 0.
  - AXIS_S_TREADY = 0 while RST_N is low.
  - Reset mid-group or mid-SEND discards the partial result; no output beat is produced.
- Beat definitions: an S beat is TVALID&TREADY on the slave; an M beat is TVALID&TREADY on the master.
- Registers:
  - acc: TDATAW bits.
  - cnt: CNTW = $clog2(NOPS+1) bits, counting operands accepted.
  - ovf: sticky flag.
  - tid: TIDW bits.
- States (adder_pkg::state_t, 2 bits): IDLE, ACCUM, SEND.
- IDLE:
  - S_TREADY=1.
  - On an S beat: acc<=TDATA, cnt<=1, ovf<=0, tid<=TID.
  - Next state is SEND if TLAST, else ACCUM.
- ACCUM:
  - S_TREADY=1.
  - On an S beat: acc<=sum(acc,TDATA), ovf<=ovf|carry, cnt<=cnt+1.
  - Next state is SEND if TLAST or cnt+1==NOPS, else stay in ACCUM.
- SEND:
  - M_TVALID=1; TDATA=acc, TID=tid, TUSER=ovf, TLAST=1, TDEST=RESULT_DEST.
  - S_TREADY=M_TREADY.
  - M beat with no S beat: go to IDLE.
  - M beat with a simultaneous S beat: load as the IDLE first-beat case, then go to ACCUM or SEND. This gives zero-bubble chaining.
  - M_TVALID held and outputs stable until M_TREADY; no combinational path from S_TVALID to M_*.
- Latency: result valid the cycle after the group's final S beat.
- Throughput: one operand per cycle sustained.
- Arithmetic:
  - Unsigned, TDATAW+1-bit add; carry = bit TDATAW.
  - Without the optional feature, the result wraps modulo 2^TDATAW.
- Group-length boundaries:
  - A 1-beat group (TLAST on the first beat) outputs that operand unchanged with ovf=0.
  - TLAST on beat NOPS is consistent; there is no extra output.
  - A group longer than NOPS without TLAST is split: beat NOPS+1 starts a new group with TID resampled.
- AXIS_S_TDEST is unused; no assertion is raised on it.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined:
  - On any carry, acc saturates to all-ones and stays saturated for the rest of the group.
  - ovf is set as usual.
- Undefined:
  - Wrapping add; ovf is still reported.
- Port list is identical in both builds.

Decomposition:
- Package adder_pkg:
  - state_t enum {IDLE, ACCUM, SEND}.
  - Function cnt_w(nops) returning $clog2(nops+1).
- Sub-module axis_sat_add:
  - Combinational, TDATAW-parameterised.
  - Inputs a, b; outputs sum, carry.
  - Contains the ADDER_SAT_EN switch so the FSM is identical in both builds.

Test Plan:
- NOPS=2, operands 5, 7 (no TLAST), M_TREADY=1 -> one beat: TDATA=12, TLAST=1, TDEST=1, TUSER=0, TID = first beat's TID; valid 1 cycle after 7 accepted.
- NOPS=4, operands 1, 2, 3 with TLAST on 3 -> TDATA=6; next group 10, 20, 30, 40 without TLAST -> TDATA=100 after the 4th beat.
- TDATAW=8, operands 0xF0, 0x20 -> without macro TDATA=0x10, TUSER=1; with ADDER_SAT_EN TDATA=0xFF, TUSER=1.
- M_TREADY low for 5 cycles in SEND -> S_TREADY=0 and TDATA/TID stable throughout. Then raise M_TREADY with a new operand 9 (TID=2) valid -> both handshakes in the same cycle and next result TID=2.
- Continuous stream of 8 operands, NOPS=2, M_TREADY=1 -> 4 results, no idle cycle on S_TREADY.
- Assert RST_N low after 1 of 2 operands -> no output beat; after release, operands 3, 4 -> TDATA=7.
